// File: rtl/sin_freq_ramp_ctrl_if.sv
// Bundle between the frequency PIO, the NCO wrap strobe and the ramp controller.
// The master drives requests and the wrap pulse; the slave returns the active word and status.
interface sin_freq_ramp_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             enable;
  logic [WIDTH-1:0] target_freq;
  logic [15:0]      step_size;
  logic             phase_wrap;
  logic [WIDTH-1:0] freq_word;
  logic             freq_update;
  logic             busy;
  logic             at_target;

  modport master (
    output enable, target_freq, step_size, phase_wrap,
    input  freq_word, freq_update, busy, at_target
  );

  modport slave (
    input  enable, target_freq, step_size, phase_wrap,
    output freq_word, freq_update, busy, at_target
  );
endinterface

// File: rtl/sin_freq_ramp_ctrl.sv
// Ramps the NCO frequency word toward the PIO target in bounded steps,
// committing each step only on a phase-accumulator wrap.
module sin_freq_ramp_ctrl #(
  parameter int WIDTH    = 32,
  parameter int TICK_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sin_freq_ramp_ctrl_if.slave  bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RAMP  = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] freq_word_q, freq_word_d;
  logic             freq_update_q, freq_update_d;
  logic             busy_q, busy_d;
  logic             at_target_q, at_target_d;

  logic [WIDTH-1:0] step_ext_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] next_val_s;
  logic             counting_s;
  logic             tick_s;
  logic             commit_s;

  // Next candidate word: clamp to the target when within one step, so no wrap-around is possible.
  always_comb begin
    step_ext_s = {{(WIDTH-16){1'b0}}, bus.step_size};
    if (bus.target_freq >= freq_word_q) begin
      diff_s = bus.target_freq - freq_word_q;
    end else begin
      diff_s = freq_word_q - bus.target_freq;
    end
    if ((bus.step_size == 16'd0) || (diff_s <= step_ext_s)) begin
      next_val_s = bus.target_freq;
    end else if (bus.target_freq > freq_word_q) begin
      next_val_s = freq_word_q + step_ext_s;
    end else begin
      next_val_s = freq_word_q - step_ext_s;
    end
  end

  // Tick divider: free-runs only while ramping, otherwise held at zero.
  always_comb begin
    counting_s = bus.enable && (state_q == ST_RAMP);
    tick_s     = counting_s && (cnt_q == TICK_LAST);
    if (!counting_s || tick_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Sequencer: disabling always wins and drops any armed step without committing it.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    freq_word_d = freq_word_q;
    commit_s    = 1'b0;
    if (!bus.enable) begin
      state_d   = ST_IDLE;
      pending_d = {WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.target_freq != freq_word_q) begin
            if (bus.step_size == 16'd0) begin
              state_d   = ST_ARMED;
              pending_d = bus.target_freq;
            end else begin
              state_d = ST_RAMP;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RAMP: begin
          if (bus.target_freq == freq_word_q) begin
            state_d = ST_IDLE;
          end else if (tick_s) begin
            state_d   = ST_ARMED;
            pending_d = next_val_s;
          end else begin
            state_d = ST_RAMP;
          end
        end
        ST_ARMED: begin
          if (bus.phase_wrap) begin
            commit_s    = 1'b1;
            freq_word_d = pending_q;
            state_d     = (pending_q == bus.target_freq) ? ST_IDLE : ST_RAMP;
          end else begin
            state_d = ST_ARMED;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          pending_d = {WIDTH{1'b0}};
        end
      endcase
    end
    freq_update_d = commit_s;
    busy_d        = (state_d != ST_IDLE);
    at_target_d   = (freq_word_d == bus.target_freq);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      pending_q     <= {WIDTH{1'b0}};
      freq_word_q   <= {WIDTH{1'b0}};
      freq_update_q <= 1'b0;
      busy_q        <= 1'b0;
      at_target_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      freq_word_q   <= freq_word_d;
      freq_update_q <= freq_update_d;
      busy_q        <= busy_d;
      at_target_q   <= at_target_d;
    end
  end

  assign bus.freq_word   = freq_word_q;
  assign bus.freq_update = freq_update_q;
  assign bus.busy        = busy_q;
  assign bus.at_target   = at_target_q;
endmodule

// File: tb/tb_sin_freq_ramp_ctrl.sv
// Directed bench for sin_freq_ramp_ctrl with a short tick divider and a wrap every 10 cycles.
module tb_sin_freq_ramp_ctrl;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   cyc;
  logic wrap_en;
  logic wrapped;

  sin_freq_ramp_ctrl_if #(.WIDTH(32)) bus ();

  sin_freq_ramp_ctrl #(.WIDTH(32), .TICK_DIV(4), .CNT_W(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_pw(input logic pw);
    bus.phase_wrap = pw;
    wrapped = pw;
    @(posedge clk);
    #1;
    cyc++;
    bus.phase_wrap = 1'b0;
  endtask

  task automatic step();
    step_pw(wrap_en && (cyc % 10 == 9));
  endtask

  task automatic expect_commit(input logic [31:0] exp, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      step();
      if (bus.freq_update === 1'b1) found = 1'b1;
    end
    chk({tag, "_seen"}, {31'd0, found}, 32'd1);
    if (found) begin
      chk({tag, "_word"}, bus.freq_word, exp);
      chk({tag, "_onwrap"}, {31'd0, wrapped}, 32'd1);
      step();
      chk({tag, "_pulse1"}, {31'd0, bus.freq_update}, 32'd0);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; wrap_en = 1'b0; wrapped = 1'b0;
    rst = 1'b1;
    bus.enable = 1'b0; bus.target_freq = 32'd0; bus.step_size = 16'd0; bus.phase_wrap = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_word", bus.freq_word, 32'd0);
    chk("rst_upd", {31'd0, bus.freq_update}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_attgt", {31'd0, bus.at_target}, 32'd1);
    rst = 1'b0;
    step_pw(1'b0);
    step_pw(1'b0);
    chk("idle_attgt", {31'd0, bus.at_target}, 32'd1);

    // Ramp up 0 -> 250 in steps of 100.
    bus.step_size = 16'd100; bus.target_freq = 32'd250; bus.enable = 1'b1; wrap_en = 1'b1;
    expect_commit(32'd100, "up1");
    expect_commit(32'd200, "up2");
    expect_commit(32'd250, "up3");
    chk("up_busy", {31'd0, bus.busy}, 32'd0);
    chk("up_attgt", {31'd0, bus.at_target}, 32'd1);

    // Ramp down 250 -> 0.
    bus.target_freq = 32'd0;
    step();
    chk("dn_attgt0", {31'd0, bus.at_target}, 32'd0);
    chk("dn_busy1", {31'd0, bus.busy}, 32'd1);
    expect_commit(32'd150, "dn1");
    expect_commit(32'd50, "dn2");
    expect_commit(32'd0, "dn3");
    chk("dn_busy", {31'd0, bus.busy}, 32'd0);
    chk("dn_attgt", {31'd0, bus.at_target}, 32'd1);

    // Target change while ARMED with pending 100.
    wrap_en = 1'b0; bus.target_freq = 32'd250;
    repeat (8) step();
    chk("arm_busy", {31'd0, bus.busy}, 32'd1);
    chk("arm_word", bus.freq_word, 32'd0);
    bus.target_freq = 32'd50; wrap_en = 1'b1;
    expect_commit(32'd100, "chg1");
    expect_commit(32'd50, "chg2");
    chk("chg_busy", {31'd0, bus.busy}, 32'd0);
    chk("chg_attgt", {31'd0, bus.at_target}, 32'd1);

    // Disable while ARMED, coinciding with a wrap.
    wrap_en = 1'b0; bus.target_freq = 32'd250;
    repeat (8) step();
    chk("dis_busy_pre", {31'd0, bus.busy}, 32'd1);
    bus.enable = 1'b0;
    step_pw(1'b1);
    chk("dis_upd", {31'd0, bus.freq_update}, 32'd0);
    chk("dis_word", bus.freq_word, 32'd50);
    chk("dis_busy", {31'd0, bus.busy}, 32'd0);
    repeat (3) step_pw(1'b0);
    chk("dis_hold", bus.freq_word, 32'd50);
    chk("dis_attgt", {31'd0, bus.at_target}, 32'd0);

    // Direct jump with step_size 0.
    bus.step_size = 16'd0; bus.target_freq = 32'h12345678; bus.enable = 1'b1; wrap_en = 1'b1;
    step();
    chk("jmp_busy", {31'd0, bus.busy}, 32'd1);
    expect_commit(32'h12345678, "jmp");
    chk("jmp_idle", {31'd0, bus.busy}, 32'd0);
    chk("jmp_attgt", {31'd0, bus.at_target}, 32'd1);

    // Asynchronous reset mid-ramp with freq_word = 200.
    rst = 1'b1;
    step_pw(1'b0);
    rst = 1'b0;
    bus.step_size = 16'd100; bus.target_freq = 32'd250;
    expect_commit(32'd100, "rr1");
    expect_commit(32'd200, "rr2");
    wrap_en = 1'b0;
    repeat (8) step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_word", bus.freq_word, 32'd0);
    chk("arst_attgt", {31'd0, bus.at_target}, 32'd1);
    chk("arst_upd", {31'd0, bus.freq_update}, 32'd0);
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    step_pw(1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_pw(1'b0);
      chk("arst_noupd", {31'd0, bus.freq_update}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
